// File: rtl/huff_pkg.sv
// huff_pkg: shared types and constants for the Huffman encoder.
//   HUFF_MAX_CHARS : default string length / distinct-character limit
//   HUFF_WW        : node weight (and code length) width
//   HUFF_NUM_NODES : leaves plus internal nodes of a full tree
//   HUFF_IW        : node index width
//   state_t        : controller states
//   node_t         : one tree node (leaf or internal)
//   len_to_mask    : code length -> low-bits mask
package huff_pkg;

   localparam int HUFF_MAX_CHARS = 10;
   localparam int HUFF_WW        = $clog2(HUFF_MAX_CHARS + 1);
   localparam int HUFF_NUM_NODES = 2 * HUFF_MAX_CHARS - 1;
   localparam int HUFF_IW        = $clog2(HUFF_NUM_NODES);

   typedef enum logic [2:0] {IDLE, COUNT, MERGE, ENCODE, DONE} state_t;

   // parent == 0 means "no parent": parents are always internal nodes,
   // which live at index HUFF_MAX_CHARS and above.
   typedef struct packed {
      logic [HUFF_WW-1:0]        weight;
      logic [7:0]                ch;
      logic [HUFF_IW-1:0]        left;
      logic [HUFF_IW-1:0]        right;
      logic [HUFF_IW-1:0]        parent;
      logic                      is_leaf;
      logic                      active;
      logic [HUFF_MAX_CHARS-1:0] code;
      logic [HUFF_WW-1:0]        len;
   } node_t;

   function automatic logic [HUFF_MAX_CHARS-1:0] len_to_mask(input logic [HUFF_WW-1:0] len);
      logic [HUFF_MAX_CHARS-1:0] m;
      for (int i = 0; i < HUFF_MAX_CHARS; i++)
         m[i] = (HUFF_WW'(i) < len);
      return m;
   endfunction

endpackage

// File: rtl/huff_min2_finder.sv
// huff_min2_finder: combinational search for the two lightest active nodes.
//   nodes      in  node array
//   first_idx  out index of the lightest active node (lowest index on ties)
//   second_idx out index of the next lightest active node (lowest index on ties)
module huff_min2_finder
   import huff_pkg::*;
#(
   parameter int NN = HUFF_NUM_NODES,
   parameter int IW = HUFF_IW
) (
   input  node_t          nodes [NN],
   output logic [IW-1:0]  first_idx,
   output logic [IW-1:0]  second_idx
);

   logic               found_1, found_2;
   logic [HUFF_WW-1:0] min_1, min_2;

   // Ascending scan with strict '<' keeps the lower index on equal weights.
   always_comb begin
      first_idx  = '0;
      second_idx = '0;
      found_1    = 1'b0;
      found_2    = 1'b0;
      min_1      = '0;
      min_2      = '0;
      for (int i = 0; i < NN; i++) begin
         if (nodes[i].active && (!found_1 || nodes[i].weight < min_1)) begin
            found_1   = 1'b1;
            min_1     = nodes[i].weight;
            first_idx = IW'(i);
         end
      end
      for (int i = 0; i < NN; i++) begin
         if (nodes[i].active && IW'(i) != first_idx &&
             (!found_2 || nodes[i].weight < min_2)) begin
            found_2    = 1'b1;
            min_2      = nodes[i].weight;
            second_idx = IW'(i);
         end
      end
   end

endmodule

// File: rtl/huffman_encoder.sv
// huffman_encoder: single-shot Huffman code-table generator.
//   clk            rising-edge clock
//   reset          synchronous, active-high; aborts any run
//   data_in        right-justified byte string, 0x00 = empty slot
//   freq_in        reserved, ignored
//   character      distinct character per slot, ascending byte order
//   encoded_value  LSB-aligned code per slot
//   encoded_mask   low code-length bits set per slot
//   done           table valid, held until reset
// Optional: define HUFF_DEBUG_TRACE_EN for a simulation-only trace of every
// state change (state, merge count, node array with partial codes).
//
// state  | meaning
// IDLE   | latch data_in on first edge out of reset
// COUNT  | build sorted leaves and weights, publish characters
// MERGE  | combine two lightest active nodes, one per cycle
// ENCODE | push codes one tree level down per cycle
// DONE   | table valid, hold until reset
module huffman_encoder
   import huff_pkg::*;
#(
   parameter int MAX_CHAR_COUNT = HUFF_MAX_CHARS,
   parameter int WW             = $clog2(MAX_CHAR_COUNT + 1)
) (
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic [MAX_CHAR_COUNT-1:0][7:0]                  data_in,
   input  logic [0:MAX_CHAR_COUNT-1][2:0]                  freq_in,
   output logic [MAX_CHAR_COUNT-1:0][7:0]                  character,
   output logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0]   encoded_value,
   output logic [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0]   encoded_mask,
   output logic                                            done
);

   localparam int NN = 2 * MAX_CHAR_COUNT - 1;
   localparam int IW = $clog2(NN);

   state_t                        state;
   logic [MAX_CHAR_COUNT-1:0][7:0] str_q;
   node_t                         nodes [NN];
   logic [WW-1:0]                 uniq;
   logic [WW-1:0]                 step_cnt;

   logic unused_freq;
   assign unused_freq = ^freq_in;

   // Leaf construction: a byte is counted once, at its first occurrence; its
   // slot is the number of distinct smaller bytes, which gives ascending order.
   logic [MAX_CHAR_COUNT-1:0] is_first;
   logic [WW-1:0]             occ     [MAX_CHAR_COUNT];
   logic [WW-1:0]             rank    [MAX_CHAR_COUNT];
   logic [7:0]                leaf_ch [MAX_CHAR_COUNT];
   logic [WW-1:0]             leaf_w  [MAX_CHAR_COUNT];
   logic [WW-1:0]             uniq_c;

   always_comb begin
      for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
         is_first[i] = (str_q[i] != 8'h00);
         for (int j = 0; j < i; j++)
            if (str_q[j] == str_q[i]) is_first[i] = 1'b0;
      end
   end

   always_comb begin
      uniq_c = '0;
      for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
         occ[i]  = '0;
         rank[i] = '0;
         for (int j = 0; j < MAX_CHAR_COUNT; j++) begin
            if (str_q[j] == str_q[i]) occ[i] = occ[i] + 1'b1;
            if (is_first[j] && str_q[j] < str_q[i]) rank[i] = rank[i] + 1'b1;
         end
         uniq_c = uniq_c + WW'(is_first[i]);
      end
      for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
         leaf_ch[k] = 8'h00;
         leaf_w[k]  = '0;
         for (int i = 0; i < MAX_CHAR_COUNT; i++) begin
            if (is_first[i] && rank[i] == WW'(k)) begin
               leaf_ch[k] = str_q[i];
               leaf_w[k]  = occ[i];
            end
         end
      end
   end

   logic [IW-1:0] sel_a, sel_b, new_idx;

   huff_min2_finder #(.NN(NN), .IW(IW)) u_min2 (
      .nodes      (nodes),
      .first_idx  (sel_a),
      .second_idx (sel_b)
   );

   assign new_idx = IW'(MAX_CHAR_COUNT) + IW'(step_cnt);

   // Every node recomputes its code from its parent's registered code, so
   // depth d is correct after d cycles; the tree is at most uniq-1 deep.
   logic [HUFF_MAX_CHARS-1:0] enc_code [NN];
   logic [HUFF_WW-1:0]        enc_len  [NN];

   always_comb begin
      for (int i = 0; i < NN; i++) begin
         enc_code[i] = nodes[i].code;
         enc_len[i]  = nodes[i].len;
         if (nodes[i].parent != '0) begin
            enc_code[i] = {nodes[nodes[i].parent].code[HUFF_MAX_CHARS-2:0],
                           nodes[nodes[i].parent].right == IW'(i)};
            enc_len[i]  = nodes[nodes[i].parent].len + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         str_q         <= '0;
         uniq          <= '0;
         step_cnt      <= '0;
         character     <= '0;
         encoded_value <= '0;
         encoded_mask  <= '0;
         done          <= 1'b0;
         for (int i = 0; i < NN; i++) nodes[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               str_q <= data_in;
               state <= COUNT;
            end
            COUNT: begin
               for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
                  nodes[k] <= '{weight: leaf_w[k], ch: leaf_ch[k], left: '0, right: '0,
                                parent: '0, is_leaf: 1'b1, active: (WW'(k) < uniq_c),
                                code: '0, len: '0};
                  character[k] <= leaf_ch[k];
               end
               uniq     <= uniq_c;
               step_cnt <= '0;
               if (uniq_c < WW'(2)) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  state <= MERGE;
               end
            end
            MERGE: begin
               nodes[new_idx] <= '{weight: nodes[sel_a].weight + nodes[sel_b].weight,
                                   ch: 8'h00, left: sel_a, right: sel_b, parent: '0,
                                   is_leaf: 1'b0, active: 1'b1, code: '0, len: '0};
               nodes[sel_a].active <= 1'b0;
               nodes[sel_a].parent <= new_idx;
               nodes[sel_b].active <= 1'b0;
               nodes[sel_b].parent <= new_idx;
               if (step_cnt == uniq - WW'(2)) begin
                  step_cnt <= '0;
                  state    <= ENCODE;
               end else begin
                  step_cnt <= step_cnt + 1'b1;
               end
            end
            ENCODE: begin
               for (int i = 0; i < NN; i++) begin
                  nodes[i].code <= enc_code[i];
                  nodes[i].len  <= enc_len[i];
               end
               if (step_cnt == uniq - WW'(2)) begin
                  for (int k = 0; k < MAX_CHAR_COUNT; k++) begin
                     encoded_value[k] <= enc_code[k];
                     encoded_mask[k]  <= len_to_mask(enc_len[k]);
                  end
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  step_cnt <= step_cnt + 1'b1;
               end
            end
            DONE: ;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef HUFF_DEBUG_TRACE_EN
   state_t trace_prev;
   always @(posedge clk) begin
      if (state != trace_prev) begin
         $display("huff %0t: state=%s merges=%0d", $time, state.name(), step_cnt);
         for (int i = 0; i < NN; i++)
            $display("  node %0d w=%0d ch=%02h l=%0d r=%0d p=%0d leaf=%0b act=%0b code=%b len=%0d",
                     i, nodes[i].weight, nodes[i].ch, nodes[i].left, nodes[i].right,
                     nodes[i].parent, nodes[i].is_leaf, nodes[i].active,
                     nodes[i].code, nodes[i].len);
      end
      trace_prev <= state;
   end
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
module tb_huffman_encoder;

   localparam int M = 10;
   localparam int LAT_MAX = 2 * M + 3;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic [M-1:0][7:0]      data_in = '0;
   logic [0:M-1][2:0]      freq_in = '0;
   logic [M-1:0][7:0]      character;
   logic [M-1:0][M-1:0]    encoded_value;
   logic [M-1:0][M-1:0]    encoded_mask;
   logic                   done;

   huffman_encoder #(.MAX_CHAR_COUNT(M)) dut (
      .clk           (clk),
      .reset         (reset),
      .data_in       (data_in),
      .freq_in       (freq_in),
      .character     (character),
      .encoded_value (encoded_value),
      .encoded_mask  (encoded_mask),
      .done          (done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int last_cycles;

   logic [7:0]   exp_ch   [M];
   logic [M-1:0] exp_val  [M];
   logic [M-1:0] exp_mask [M];

   // Reference: count, sort distinct bytes, repeatedly merge the two lightest
   // nodes (index breaks ties), then read each code by walking leaf -> root.
   task automatic compute_model(input logic [8*M-1:0] s);
      int w [256];
      int nw [2*M];
      int par [2*M];
      int bt [2*M];
      bit act [2*M];
      int u, a, b, id, n, len;
      logic [M-1:0] code;
      logic [7:0] by;
      for (int v = 0; v < 256; v++) w[v] = 0;
      for (int i = 0; i < M; i++) begin
         by = s[i*8 +: 8];
         if (by != 8'h00) w[by]++;
      end
      for (int k = 0; k < 2*M; k++) begin nw[k] = 0; par[k] = -1; bt[k] = 0; act[k] = 0; end
      for (int k = 0; k < M; k++) begin exp_ch[k] = '0; exp_val[k] = '0; exp_mask[k] = '0; end
      u = 0;
      for (int v = 1; v < 256; v++) begin
         if (w[v] > 0) begin
            exp_ch[u] = 8'(v);
            nw[u] = w[v];
            act[u] = 1;
            u++;
         end
      end
      if (u >= 2) begin
         for (int m = 0; m < u - 1; m++) begin
            a = -1; b = -1;
            for (int i = 0; i < 2*M; i++)
               if (act[i] && (a < 0 || nw[i] < nw[a])) a = i;
            for (int i = 0; i < 2*M; i++)
               if (act[i] && i != a && (b < 0 || nw[i] < nw[b])) b = i;
            id = M + m;
            nw[id] = nw[a] + nw[b];
            act[id] = 1; act[a] = 0; act[b] = 0;
            par[a] = id; bt[a] = 0;
            par[b] = id; bt[b] = 1;
         end
         for (int k = 0; k < u; k++) begin
            code = '0; len = 0; n = k;
            while (par[n] >= 0) begin
               code[len] = bt[n][0];
               len++;
               n = par[n];
            end
            exp_val[k] = code;
            for (int i = 0; i < len; i++) exp_mask[k][i] = 1'b1;
         end
      end
   endtask

   // Runs one encode from reset; scrambles data_in after the latch edge.
   task automatic apply(input logic [8*M-1:0] s);
      data_in = s;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      last_cycles = 0;
      while (done !== 1'b1 && last_cycles < 60) begin
         @(posedge clk); #1;
         last_cycles++;
         if (last_cycles == 1)
            for (int i = 0; i < M; i++) data_in[i] = 8'($urandom);
      end
   endtask

   task automatic test_reset();
      data_in = "anusha";
      reset = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      n_vec++;
      if (done !== 1'b0 || character !== '0 || encoded_value !== '0 || encoded_mask !== '0) begin
         n_err++;
         $display("FAIL reset: got done=%b ch=%h val=%h mask=%h, expected all zero", done, character, encoded_value, encoded_mask);
      end
   endtask

   task automatic test_directed();
      logic [8*M-1:0] dir [8];
      dir[0] = "aabb";  dir[1] = "aaf";  dir[2] = "anusha"; dir[3] = "~}|";
      dir[4] = "zzzz";  dir[5] = '0;     dir[6] = "abcdefghij"; dir[7] = "aaaaaaaaab";
      for (int t = 0; t < 8; t++) begin
         compute_model(dir[t]);
         apply(dir[t]);
         n_vec++;
         if (done !== 1'b1 || last_cycles > LAT_MAX) begin
            n_err++;
            $display("FAIL directed %0d latency: got done=%b after %0d cycles, expected done within %0d", t, done, last_cycles, LAT_MAX);
         end
         for (int k = 0; k < M; k++) begin
            n_vec++;
            if (character[k] !== exp_ch[k] || encoded_value[k] !== exp_val[k] || encoded_mask[k] !== exp_mask[k]) begin
               n_err++;
               $display("FAIL directed %0d slot %0d: got ch=%02h val=%b mask=%b, expected ch=%02h val=%b mask=%b",
                        t, k, character[k], encoded_value[k], encoded_mask[k], exp_ch[k], exp_val[k], exp_mask[k]);
            end
         end
         if (t == 2) begin
            n_vec++;
            if (character[0] !== "a" || encoded_value[0] !== 10'b10 || encoded_mask[0] !== 10'b11 ||
                character[1] !== "h" || encoded_value[1] !== 10'b110 || encoded_mask[1] !== 10'b111 ||
                encoded_value[3] !== 10'b00 || encoded_value[4] !== 10'b01) begin
               n_err++;
               $display("FAIL anusha codes: got a=%b h=%b s=%b u=%b, expected a=10 h=110 s=00 u=01",
                        encoded_value[0], encoded_value[1], encoded_value[3], encoded_value[4]);
            end
         end
         if (t == 3) begin
            n_vec++;
            if (character[0] !== "|" || encoded_value[0] !== 10'b10 || encoded_value[1] !== 10'b11 ||
                encoded_value[2] !== 10'b0 || encoded_mask[2] !== 10'b1) begin
               n_err++;
               $display("FAIL tilde codes: got |=%b }=%b ~=%b mask~=%b, expected 10 11 0 1",
                        encoded_value[0], encoded_value[1], encoded_value[2], encoded_mask[2]);
            end
         end
      end
   endtask

   task automatic test_hold_after_done();
      compute_model("zzzz");
      apply("zzzz");
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < M; i++) begin
            freq_in[i] = 3'($urandom);
            data_in[i] = 8'($urandom);
         end
         @(posedge clk); #1;
      end
      n_vec++;
      if (done !== 1'b1 || character[0] !== "z") begin
         n_err++;
         $display("FAIL hold: got done=%b ch0=%02h, expected done=1 ch0=7a", done, character[0]);
      end
      for (int k = 0; k < M; k++) begin
         n_vec++;
         if (character[k] !== exp_ch[k] || encoded_value[k] !== exp_val[k] || encoded_mask[k] !== exp_mask[k]) begin
            n_err++;
            $display("FAIL hold slot %0d: got ch=%02h val=%b mask=%b, expected ch=%02h val=%b mask=%b",
                     k, character[k], encoded_value[k], encoded_mask[k], exp_ch[k], exp_val[k], exp_mask[k]);
         end
      end
      freq_in = '0;
   endtask

   task automatic test_reset_mid_merge();
      data_in = "anusha";
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);   // IDLE, COUNT, first merge
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (done !== 1'b0 || character !== '0 || encoded_value !== '0 || encoded_mask !== '0) begin
         n_err++;
         $display("FAIL mid-merge reset: got done=%b ch=%h val=%h mask=%h, expected all zero", done, character, encoded_value, encoded_mask);
      end
      compute_model("anusha");
      apply("anusha");
      for (int k = 0; k < M; k++) begin
         n_vec++;
         if (character[k] !== exp_ch[k] || encoded_value[k] !== exp_val[k] || encoded_mask[k] !== exp_mask[k]) begin
            n_err++;
            $display("FAIL rerun slot %0d: got ch=%02h val=%b mask=%b, expected ch=%02h val=%b mask=%b",
                     k, character[k], encoded_value[k], encoded_mask[k], exp_ch[k], exp_val[k], exp_mask[k]);
         end
      end
   endtask

   task automatic test_random();
      logic [8*M-1:0] s;
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < M; i++) begin
            if (t % 4 == 3)
               s[i*8 +: 8] = 8'($urandom_range(1, 255));
            else if ($urandom_range(0, 4) == 0 && t % 4 != 0)
               s[i*8 +: 8] = 8'h00;
            else
               s[i*8 +: 8] = 8'($urandom_range(97, 97 + (t % 7)));
         end
         compute_model(s);
         apply(s);
         n_vec++;
         if (done !== 1'b1 || last_cycles > LAT_MAX) begin
            n_err++;
            $display("FAIL random %0d latency: got done=%b after %0d cycles, expected done within %0d", t, done, last_cycles, LAT_MAX);
         end
         for (int k = 0; k < M; k++) begin
            n_vec++;
            if (character[k] !== exp_ch[k] || encoded_value[k] !== exp_val[k] || encoded_mask[k] !== exp_mask[k]) begin
               n_err++;
               $display("FAIL random %0d slot %0d: got ch=%02h val=%b mask=%b, expected ch=%02h val=%b mask=%b",
                        t, k, character[k], encoded_value[k], encoded_mask[k], exp_ch[k], exp_val[k], exp_mask[k]);
            end
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_directed();
      test_hold_after_done();
      test_reset_mid_merge();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/huffman_encoder.md
Name: huffman_encoder

Overview:
- Single-shot Huffman encoder. After reset it takes a packed byte string, counts each distinct character, builds a Huffman tree and emits one variable-length code plus bit mask per distinct character.
- Sits as a stand-alone compression front end. A higher level captures the code table once `done` rises.

Parameters:
- MAX_CHAR_COUNT, 10: max string length and max number of distinct characters. Each code is at most MAX_CHAR_COUNT bits.
- WW, $clog2(MAX_CHAR_COUNT+1): node weight width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- data_in  in  [MAX_CHAR_COUNT-1:0][7:0]  string, right-justified; data_in[0] = last character; byte 0x00 = empty slot, ignored.
- freq_in  in  [0:MAX_CHAR_COUNT-1][2:0]  reserved; ignored; tie to 0.
- character  out  [MAX_CHAR_COUNT-1:0][7:0]  distinct character in slot i.
- encoded_value  out  [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0]  code for slot i, LSB-aligned.
- encoded_mask  out  [MAX_CHAR_COUNT-1:0][MAX_CHAR_COUNT-1:0]  low L bits set, L = code length of slot i.
- done  out  1  table valid; held high until reset.

Behaviour:
- Reset (synchronous, active-high):
  - all outputs 0; state=IDLE; tree cleared.
  - Asserting reset in any state aborts the run and returns to IDLE on that edge.
- IDLE: on the first edge with reset=0, latch data_in, then go to COUNT. Later data_in changes are ignored until the next reset.
- COUNT (1 cycle):
  - Build leaves, one per distinct non-zero byte, in ascending byte value. Leaf index k = slot k.
  - Weight = occurrence count. U = number of distinct characters.
  - character[k] = byte. Unused slots stay 0.
- Branches out of COUNT:
  - U=0: go to DONE; all masks 0.
  - U=1: go to DONE; mask 0 and value 0 ("no encoding for a single character").
  - Otherwise go to MERGE.
- MERGE (one merge per cycle, U-1 cycles):
  - Select the two smallest-weight active nodes. Ties go to the lower node index.
  - Internal node k is created at index MAX_CHAR_COUNT+k, so internals always rank after leaves on ties.
  - The first-selected node becomes child bit 0; the second becomes child bit 1.
  - The new node has weight = sum and is active; both children are deactivated.
  - Go to ENCODE when one active node remains (the root).
- ENCODE (≤ MAX_CHAR_COUNT cycles): propagate codes top-down, one tree level per cycle.
  - child code = {parent code, bit}; child length = parent length + 1; root length = 0.
  - A leaf's final code is written to encoded_value[slot]; encoded_mask[slot] = (1<<len)-1.
  - The first (root-level) bit sits at position len-1.
- DONE: done=1; outputs stable; remain here until reset.
- Latency: done rises no later than 2*MAX_CHAR_COUNT+3 cycles after the first edge with reset low.
- String lengths: full-length strings (no zero bytes) are legal; strings with all bytes 0 yield U=0.
- Weights never overflow WW bits.

Optional Feature:
- Macro HUFF_DEBUG_TRACE_EN.
- Defined: at every state change, simulation-only $display of state, merge count, full node array and per-node partial codes. No synthesizable logic changes.
- Undefined: no display statements are compiled; function is identical.

Decomposition:
- Package huff_pkg holds:
  - default MAX_CHAR_COUNT;
  - state_t enum {IDLE, COUNT, MERGE, ENCODE, DONE};
  - node_t struct {weight, ch, left, right, parent, is_leaf, active, code, len}.
- Sub-module huff_min2_finder: combinational. Inputs: node array. Outputs: indices of the two smallest active nodes, with the lower-index tie rule.

Test Plan:
- "aabb" → slot0 'a' value 0 mask 1; slot1 'b' value 1 mask 1; done=1; slots 2+ zero.
- "aaf" → 'a' value 1 mask 1; 'f' value 0 mask 1.
- "anusha":
  - codes: 'a' 10 (mask 11); 'h' 110 (mask 111); 'n' 111 (mask 111); 's' 00 (mask 11); 'u' 01 (mask 11).
  - done within 23 cycles.
- "~}|" (three distinct, weight 1 each):
  - leaves idx0 '|', idx1 '}', idx2 '~'.
  - Merge 1 pairs '|' and '}'. Merge 2 pairs '~' (bit 0) with that internal node (bit 1).
  - Codes: '|' 10, '}' 11, '~' 0 (mask 1).
- "zzzz" → slot0 'z', mask 0, value 0, done=1. Then freq_in random → no output change.
- Reset asserted mid-MERGE on "anusha" → next edge: all outputs 0, done=0. Release → full correct table again.
